// File: rtl/imm_extend_stage.sv
// Registered immediate generator with a two-entry skid buffer between decode and execute.
// Optional feature macro: RVC_IMM_EN (enables the compressed CI immediate on immsrc 110).
module imm_extend_stage #(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [FMT_W-1:0] immsrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic             fmt_err
);

  localparam logic [FMT_W-1:0] FMT_I = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_S = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_B = FMT_W'(2);
  localparam logic [FMT_W-1:0] FMT_J = FMT_W'(3);
  localparam logic [FMT_W-1:0] FMT_U = FMT_W'(4);
  localparam logic [FMT_W-1:0] FMT_Z = FMT_W'(5);
  localparam logic [FMT_W-1:0] FMT_C = FMT_W'(6);

  logic [XLEN-1:0] imm_new;
  logic            err_new;

  logic            main_valid;
  logic [XLEN-1:0] main_imm;
  logic            main_err;
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic            skid_err;

  logic accept;
  logic emit;

  // Fill with the sign first and overwrite the low field, so no zero-width replication at any XLEN.
  always_comb begin
    imm_new = {XLEN{instr[31]}};
    err_new = 1'b0;
    case (immsrc)
      FMT_I: imm_new[11:0] = instr[31:20];
      FMT_S: imm_new[11:0] = {instr[31:25], instr[11:7]};
      FMT_B: imm_new[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J: imm_new[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U: imm_new[31:0] = {instr[31:12], 12'b0};
      FMT_Z: begin
        imm_new      = '0;
        imm_new[4:0] = instr[19:15];
      end
`ifdef RVC_IMM_EN
      FMT_C: begin
        imm_new      = {XLEN{instr[12]}};
        imm_new[4:0] = instr[6:2];
      end
`endif
      default: begin
        imm_new = '0;
        err_new = 1'b1;
      end
    endcase
  end

`ifdef RVC_IMM_EN
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[1:0];
`else
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[6:0], FMT_C};
`endif

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign emit      = main_valid & out_ready;
  assign out_valid = main_valid;
  assign immext    = main_imm;
  assign fmt_err   = main_err;

  // Skid holds an entry only while main is stalled; it drains into main before new input is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (emit) begin
        main_imm   <= skid_imm;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || emit) begin
        main_valid <= 1'b1;
        main_imm   <= imm_new;
        main_err   <= err_new;
      end else begin
        skid_valid <= 1'b1;
        skid_imm   <= imm_new;
        skid_err   <= err_new;
      end
    end else if (emit) begin
      main_valid <= 1'b0;
    end
  end

endmodule
